// File: rtl/prog_loader_pkg.sv
// Shared types and stream-format constants for the program loader.
//   HDR_LEN        : length header bytes (16-bit little-endian word count)
//   BYTES_PER_WORD : instruction bytes per 32-bit program word
//   state_t        : loader FSM state encoding
package prog_loader_pkg;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 8 * HDR_LEN;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: collects bytes into a little-endian 32-bit word.
//   clk, reset  : system clock, async active-low reset
//   clear       : return to byte 0 with an empty word
//   load        : byte_data is taken this cycle
//   byte_data   : incoming byte
//   word        : assembled word including any byte loaded this cycle, so
//                 the caller can capture a complete word on the 4th byte
//   byte_idx    : slot the next loaded byte goes into
//   word_full   : the byte loaded this cycle completes the word
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [7:0]            byte_data,
    output logic [WORD_W-1:0]     word,
    output logic [BYTE_IDX_W-1:0] byte_idx,
    output logic                  word_full
);

    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (load) begin
            word_q   <= word;
            byte_idx <= byte_idx + 1'b1;
        end
    end

    always_comb begin
        word = word_q;
        if (load) begin
            word[{byte_idx, 3'b000} +: 8] = byte_data;
        end
    end

    assign word_full = load && (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it word by word into program memory while holding the core in reset.
//   clk, reset            : system clock, async active-low reset
//   start                 : begin a session (honoured in IDLE, DONE, ERR)
//   rx_data/valid/ready   : byte stream handshake
//   imem_we/addr/wdata    : one-cycle program memory write per word
//   core_reset            : hold processor datapath (loading or failed load)
//   busy, done, error     : session in progress / completed ok / aborted
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start after reset
// LEN0     | expecting word-count low byte
// LEN1     | expecting word-count high byte; range check on acceptance
// DATA     | collecting instruction bytes, XOR into checksum
// WRITE    | single-cycle memory write of the assembled word
// CSUM     | expecting checksum byte
// DONE     | last session good; core released
// ERR      | last session aborted; core held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [63:0] BASE_ADDR  = 64'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [63:0]       imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          KW       = DEPTH_LOG2 + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << DEPTH_LOG2;

    state_t                  state;
    state_t                  state_nx;
    logic [LEN_W-1:0]        len;
    logic [KW-1:0]           k;
    logic [7:0]              csum;

    logic                    xfer;
    logic                    start_ok;
    logic                    pk_load;
    logic                    last_word;
    logic [LEN_W-1:0]        len_full;
    logic [WORD_W-1:0]       pk_word;
    logic [BYTE_IDX_W-1:0]   pk_idx;
    logic                    pk_full;

    assign rx_ready = (state == ST_LEN0) || (state == ST_LEN1) ||
                      (state == ST_DATA) || (state == ST_CSUM);
    assign xfer     = rx_valid && rx_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                (state == ST_ERR));
    assign pk_load  = (state == ST_DATA) && xfer;
    // Full length as it becomes known on the high-byte transfer.
    assign len_full  = {rx_data, len[7:0]};
    assign last_word = (32'(k) + 32'd1) >= 32'(len);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .load      (pk_load),
        .byte_data (rx_data),
        .word      (pk_word),
        .byte_idx  (pk_idx),
        .word_full (pk_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        imem_we    = 1'b0;
        busy       = 1'b0;
        core_reset = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nx = ST_LEN0;
            end
            ST_LEN0: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                if (xfer) state_nx = ST_LEN1;
            end
            ST_LEN1: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                if (xfer) begin
                    if (32'(len_full) > CAPACITY) state_nx = ST_ERR;
                    else if (len_full == '0)      state_nx = ST_CSUM;
                    else                          state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                if (pk_full) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                imem_we    = 1'b1;
                state_nx   = last_word ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                if (xfer) state_nx = (rx_data == csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start_ok) state_nx = ST_LEN0;
            end
            ST_ERR: begin
                error      = 1'b1;
                core_reset = 1'b1;
                if (start_ok) state_nx = ST_LEN0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Address and data are captured on the completing byte so they are
    // stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            k          <= '0;
            csum       <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (start_ok) begin
                len  <= '0;
                k    <= '0;
                csum <= '0;
            end
            if ((state == ST_LEN0) && xfer) len[7:0]  <= rx_data;
            if ((state == ST_LEN1) && xfer) len[15:8] <= rx_data;
            if (pk_load) csum <= csum ^ rx_data;
            if (pk_full) begin
                imem_addr  <= BASE_ADDR + (64'(k) << 2);
                imem_wdata <= pk_word;
            end
            if (state == ST_WRITE) k <= k + 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int NDUT  = 3;
    localparam int DEPTH = 256;
    localparam logic [63:0] BASES [NDUT] = '{64'h0, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [NDUT-1:0] rdy_a, we_a, crst_a, busy_a, done_a, err_a;
    logic [63:0]     addr_a  [NDUT];
    logic [31:0]     wdata_a [NDUT];

    int checks = 0;
    int errors = 0;

    logic [95:0] gotq [NDUT][$];
    logic [95:0] expq [NDUT][$];
    logic [7:0]  stream [$];
    int          consumed;
    logic        exp_done, exp_err;
    logic        stream_abort;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        prog_loader #(.DEPTH_LOG2(8), .BASE_ADDR(BASES[g])) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .rx_data    (rx_data),
            .rx_valid   (rx_valid),
            .rx_ready   (rdy_a[g]),
            .imem_we    (we_a[g]),
            .imem_addr  (addr_a[g]),
            .imem_wdata (wdata_a[g]),
            .core_reset (crst_a[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g]),
            .error      (err_a[g])
        );
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++)
            if (we_a[d] === 1'b1) gotq[d].push_back({addr_a[d], wdata_a[d]});
    end

    // ---------------- reference model ----------------
    task automatic model_session();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        n = int'({stream[1], stream[0]});
        for (int d = 0; d < NDUT; d++) expq[d].delete();
        if (n > DEPTH) begin
            exp_err = 1'b1; exp_done = 1'b0; consumed = 2;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
                x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
                for (int d = 0; d < NDUT; d++)
                    expq[d].push_back({BASES[d] + 64'(4 * i), w});
            end
            consumed = 2 + 4 * n + 1;
            exp_done = (stream[2 + 4 * n] == x);
            exp_err  = !exp_done;
        end
    endtask

    task automatic build_stream(input int n, input int nwords, input logic [7:0] corrupt);
        logic [7:0] b, x;
        logic [15:0] n16;
        n16 = 16'(n);
        stream.delete();
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        x = 8'h00;
        for (int i = 0; i < nwords * 4; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x ^= b;
        end
        stream.push_back(x ^ corrupt);
    endtask

    // ---------------- stimulus (all tasks enter/leave just after a negedge) ----
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        budget = 64;
        while (rdy_a[0] !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (rdy_a[0] !== 1'b1) begin
            errors++;
            stream_abort = 1'b1;
            $display("FAIL rx_ready_wait byte=%02h ready=%b want 1", b, rdy_a[0]);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_stream(input int gap_mode, input int inj);
        int gap;
        stream_abort = 1'b0;
        for (int i = 0; i < consumed && !stream_abort; i++) begin
            if (i == inj) pulse_start();
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(stream[i], gap);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic begin_session();
        for (int d = 0; d < NDUT; d++) gotq[d].delete();
        pulse_start();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({rdy_a[d], we_a[d], crst_a[d], busy_a[d], done_a[d], err_a[d]} !== 6'b0 ||
                addr_a[d] !== 64'h0 || wdata_a[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_values dut%0d ctl=%b addr=%h data=%h want all zero", d,
                         {rdy_a[d], we_a[d], crst_a[d], busy_a[d], done_a[d], err_a[d]},
                         addr_a[d], wdata_a[d]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed_n1();
        stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
        model_session();
        begin_session();
        send_stream(0, -1);
        checks++;
        if (gotq[0].size() != 1 || gotq[0][0] !== {64'h0, 32'h0010_0513}) begin
            errors++;
            $display("FAIL n1_write writes=%0d first=%h want 1 x %h", gotq[0].size(),
                     (gotq[0].size() > 0) ? gotq[0][0] : 96'h0, {64'h0, 32'h0010_0513});
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({done_a[d], err_a[d], crst_a[d], busy_a[d]} !== 4'b1000) begin
                errors++;
                $display("FAIL n1_status dut%0d done/err/crst/busy=%b want 1000", d,
                         {done_a[d], err_a[d], crst_a[d], busy_a[d]});
            end
        end
    endtask

    task automatic test_stall_n3();
        build_stream(3, 3, 8'h00);
        model_session();
        begin_session();
        send_stream(1, -1);
        checks++;
        if (gotq[1].size() != 3) begin
            errors++;
            $display("FAIL stall_pulses got %0d want 3", gotq[1].size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gotq[1][i][95:32] !== 64'h100 + 64'(4 * i) || gotq[1][i] !== expq[1][i]) begin
                    errors++;
                    $display("FAIL stall_write%0d got %h want %h", i, gotq[1][i], expq[1][i]);
                end
            end
        end
        checks++;
        if (done_a[1] !== 1'b1 || err_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_done done=%b err=%b want 1 0", done_a[1], err_a[1]);
        end
    endtask

    task automatic test_overflow();
        build_stream(16'h0101, 0, 8'h00);
        model_session();
        begin_session();
        send_stream(0, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({err_a[d], crst_a[d], done_a[d], busy_a[d], rdy_a[d]} !== 5'b11000 ||
                gotq[d].size() != 0) begin
                errors++;
                $display("FAIL overflow dut%0d err/crst/done/busy/rdy=%b writes=%0d want 11000 0", d,
                         {err_a[d], crst_a[d], done_a[d], busy_a[d], rdy_a[d]}, gotq[d].size());
            end
        end
    endtask

    task automatic test_bad_csum();
        build_stream(1, 1, 8'h01);
        model_session();
        begin_session();
        send_stream(0, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (gotq[d].size() != 1 || gotq[d][0] !== expq[d][0]) begin
                errors++;
                $display("FAIL badcsum_write dut%0d writes=%0d want 1 x %h", d, gotq[d].size(), expq[d][0]);
            end
            checks++;
            if ({err_a[d], done_a[d], crst_a[d], busy_a[d]} !== 4'b1010) begin
                errors++;
                $display("FAIL badcsum_status dut%0d err/done/crst/busy=%b want 1010", d,
                         {err_a[d], done_a[d], crst_a[d], busy_a[d]});
            end
        end
    endtask

    task automatic test_zero_len();
        build_stream(0, 0, 8'h00);
        model_session();
        begin_session();
        send_stream(2, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (done_a[d] !== 1'b1 || err_a[d] !== 1'b0 || gotq[d].size() != 0) begin
                errors++;
                $display("FAIL zero_len dut%0d done=%b err=%b writes=%0d want 1 0 0", d,
                         done_a[d], err_a[d], gotq[d].size());
            end
        end
    endtask

    task automatic test_reset_mid();
        build_stream(1, 1, 8'h00);
        model_session();
        begin_session();
        for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({rdy_a[d], we_a[d], crst_a[d], busy_a[d], done_a[d], err_a[d]} !== 6'b0 ||
                addr_a[d] !== 64'h0 || wdata_a[d] !== 32'h0) begin
                errors++;
                $display("FAIL midreset_values dut%0d ctl=%b addr=%h data=%h want all zero", d,
                         {rdy_a[d], we_a[d], crst_a[d], busy_a[d], done_a[d], err_a[d]},
                         addr_a[d], wdata_a[d]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (gotq[0].size() != 0) begin
            errors++;
            $display("FAIL midreset_nowrite writes=%0d want 0", gotq[0].size());
        end
        begin_session();
        send_stream(0, -1);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (done_a[d] !== 1'b1 || gotq[d].size() != 1 || gotq[d][0] !== expq[d][0]) begin
                errors++;
                $display("FAIL midreset_resume dut%0d done=%b writes=%0d want 1 1", d,
                         done_a[d], gotq[d].size());
            end
        end
    endtask

    task automatic test_start_ignored();
        build_stream(2, 2, 8'h00);
        model_session();
        begin_session();
        send_stream(0, 4);
        checks++;
        if (done_a[0] !== 1'b1 || gotq[0].size() != 2 ||
            gotq[0][0] !== expq[0][0] || gotq[0][1] !== expq[0][1]) begin
            errors++;
            $display("FAIL start_in_data done=%b writes=%0d want 1 2", done_a[0], gotq[0].size());
        end
        build_stream(1, 1, 8'h00);
        model_session();
        begin_session();
        checks++;
        if ({done_a[0], busy_a[0], crst_a[0], rdy_a[0]} !== 4'b0111) begin
            errors++;
            $display("FAIL start_in_done done/busy/crst/rdy=%b want 0111",
                     {done_a[0], busy_a[0], crst_a[0], rdy_a[0]});
        end
        send_stream(2, -1);
        checks++;
        if (done_a[0] !== 1'b1 || gotq[0].size() != 1 || gotq[0][0] !== expq[0][0]) begin
            errors++;
            $display("FAIL start_in_done_session done=%b writes=%0d want 1 1", done_a[0], gotq[0].size());
        end
    endtask

    task automatic test_boundary();
        int bad;
        build_stream(DEPTH, DEPTH, 8'h00);
        model_session();
        begin_session();
        send_stream(0, -1);
        for (int d = 0; d < NDUT; d++) begin
            bad = 0;
            if (gotq[d].size() != expq[d].size()) bad = 1;
            else for (int i = 0; i < expq[d].size(); i++) if (gotq[d][i] !== expq[d][i]) bad++;
            checks++;
            if (bad != 0 || done_a[d] !== 1'b1) begin
                errors++;
                $display("FAIL boundary_full dut%0d writes=%0d want %0d bad=%0d done=%b", d,
                         gotq[d].size(), expq[d].size(), bad, done_a[d]);
            end
        end
    endtask

    task automatic test_random();
        int mode, n, bad;
        for (int it = 0; it < 14; it++) begin
            mode = int'($urandom_range(0, 5));
            case (mode)
                0:       build_stream(int'($urandom_range(DEPTH + 1, 65535)), 0, 8'h00);
                1:       build_stream(0, 0, 8'($urandom_range(0, 1)));
                2:       begin n = int'($urandom_range(1, 6)); build_stream(n, n, 8'($urandom_range(1, 255))); end
                default: begin n = int'($urandom_range(1, 6)); build_stream(n, n, 8'h00); end
            endcase
            model_session();
            begin_session();
            send_stream(int'($urandom_range(0, 2)), -1);
            for (int d = 0; d < NDUT; d++) begin
                bad = 0;
                if (gotq[d].size() != expq[d].size()) bad = 1;
                else for (int i = 0; i < expq[d].size(); i++) if (gotq[d][i] !== expq[d][i]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand%0d_writes dut%0d got %0d writes want %0d bad=%0d", it, d,
                             gotq[d].size(), expq[d].size(), bad);
                end
                checks++;
                if ({done_a[d], err_a[d], crst_a[d], busy_a[d]} !== {exp_done, exp_err, exp_err, 1'b0}) begin
                    errors++;
                    $display("FAIL rand%0d_status dut%0d done/err/crst/busy=%b want %b", it, d,
                             {done_a[d], err_a[d], crst_a[d], busy_a[d]},
                             {exp_done, exp_err, exp_err, 1'b0});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_n1();
        test_stall_n3();
        test_overflow();
        test_bad_csum();
        test_zero_len();
        test_reset_mid();
        test_start_ignored();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
